// File: rtl/inv_stream_pkg.sv
// Shared defaults and the per-bit inversion helper for the inv_stream_bank slice.
package inv_stream_pkg;

  localparam int unsigned MAX_WIDTH = 64;
  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_CNT_W = 16;

  // Callers zero-extend to MAX_WIDTH and cast the result back to their own width.
  function automatic logic [MAX_WIDTH-1:0] inv_apply(
    input logic [MAX_WIDTH-1:0] data,
    input logic [MAX_WIDTH-1:0] static_mask,
    input logic [MAX_WIDTH-1:0] rt_mask
  );
    return data ^ static_mask ^ rt_mask;
  endfunction

endpackage

// File: rtl/inv_stream_skid.sv
// Generic 2-entry valid/ready skid buffer; in_ready is registered and never
// depends combinationally on out_ready.
module inv_stream_skid #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] skid_q, skid_n, out_n;
  logic         skid_valid, skid_valid_n, out_valid_n;
  logic         ready_q;
  logic         accept;

  assign accept   = in_valid && ready_q;
  assign in_ready = ready_q;

  always_comb begin
    skid_n       = skid_q;
    skid_valid_n = skid_valid;
    out_n        = out_data;
    out_valid_n  = out_valid;
    // Output slot is free when empty or draining this cycle; skid has priority
    // and is only ever occupied while in_ready is low, so no accept competes.
    if (out_ready || !out_valid) begin
      if (skid_valid) begin
        out_n        = skid_q;
        out_valid_n  = 1'b1;
        skid_valid_n = 1'b0;
      end else if (accept) begin
        out_n       = in_data;
        out_valid_n = 1'b1;
      end else begin
        out_valid_n = 1'b0;
      end
    end else if (accept) begin
      skid_n       = in_data;
      skid_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q     <= '0;
      skid_valid <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      skid_q     <= skid_n;
      skid_valid <= skid_valid_n;
      out_data   <= out_n;
      out_valid  <= out_valid_n;
      ready_q    <= !skid_valid_n;
    end
  end

endmodule

// File: rtl/inv_stream_bank.sv
// Streaming invertible-pin bank: static XOR runtime mask applied on accept,
// skid-buffered output. Optional out_parity via INV_STREAM_BANK_PARITY_EN.
module inv_stream_bank
  import inv_stream_pkg::*;
#(
  parameter int unsigned      WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] INV_MASK = '0,
  parameter int unsigned      CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_mask,
  output logic [WIDTH-1:0] mask_q,
`ifdef INV_STREAM_BANK_PARITY_EN
  output logic             out_parity,
`endif
  output logic [CNT_W-1:0] beat_cnt
);

  typedef struct packed {
`ifdef INV_STREAM_BANK_PARITY_EN
    logic             parity;
`endif
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t            beat_in, beat_out;
  logic [WIDTH-1:0] eff;
  logic             accept;

  assign accept = in_valid && in_ready;
  assign eff    = WIDTH'(inv_apply(MAX_WIDTH'(in_data), MAX_WIDTH'(INV_MASK),
                                   MAX_WIDTH'(mask_q)));

  always_comb begin
    beat_in      = '0;
    beat_in.data = eff;
`ifdef INV_STREAM_BANK_PARITY_EN
    beat_in.parity = ^eff;
`endif
  end

  inv_stream_skid #(
    .W($bits(beat_t))
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (beat_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (beat_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign out_data = beat_out.data;
`ifdef INV_STREAM_BANK_PARITY_EN
  assign out_parity = beat_out.parity;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q   <= '0;
      beat_cnt <= '0;
    end else begin
      if (cfg_we) mask_q <= cfg_mask;
      if (accept) beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inv_stream_bank.sv
// Directed and scoreboarded bench for inv_stream_bank (WIDTH=4, INV_MASK=4'b0001, CNT_W=4).
module tb_inv_stream_bank;

  logic       clk;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       cfg_we;
  logic [3:0] cfg_mask;
  logic [3:0] mask_q;
  logic [3:0] beat_cnt;
`ifdef INV_STREAM_BANK_PARITY_EN
  logic       out_parity;
`endif

  int errors = 0;
  int checks = 0;

  inv_stream_bank #(
    .WIDTH   (4),
    .INV_MASK(4'b0001),
    .CNT_W   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cfg_we   (cfg_we),
    .cfg_mask (cfg_mask),
    .mask_q   (mask_q),
`ifdef INV_STREAM_BANK_PARITY_EN
    .out_parity(out_parity),
`endif
    .beat_cnt (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 4'b0000) begin errors++; $display("FAIL reset_out_data got=%b exp=0000", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (mask_q !== 4'b0000) begin errors++; $display("FAIL reset_mask_q got=%b exp=0000", mask_q); end
    checks++; if (beat_cnt !== 4'd0) begin errors++; $display("FAIL reset_beat_cnt got=%0d exp=0", beat_cnt); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    in_data = 4'b1010; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_data !== 4'b1011) begin errors++; $display("FAIL basic_data got=%b exp=1011", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    checks++; if (beat_cnt !== 4'd1) begin errors++; $display("FAIL basic_cnt got=%0d exp=1", beat_cnt); end
`ifdef INV_STREAM_BANK_PARITY_EN
    checks++; if (out_parity !== 1'b1) begin errors++; $display("FAIL basic_parity got=%b exp=1", out_parity); end
`endif
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_mask();
    in_data = 4'b0000; in_valid = 1'b1; cfg_we = 1'b1; cfg_mask = 4'b1100;
    step();
    cfg_we = 1'b0;
    checks++; if (out_data !== 4'b0001) begin errors++; $display("FAIL mask_old got=%b exp=0001", out_data); end
    checks++; if (mask_q !== 4'b1100) begin errors++; $display("FAIL mask_q got=%b exp=1100", mask_q); end
    in_data = 4'b0000;
    step();
    checks++; if (out_data !== 4'b1101) begin errors++; $display("FAIL mask_new got=%b exp=1101", out_data); end
    checks++; if (beat_cnt !== 4'd3) begin errors++; $display("FAIL mask_cnt got=%0d exp=3", beat_cnt); end
    in_valid = 1'b0; cfg_we = 1'b1; cfg_mask = 4'b0000;
    step();
    cfg_we = 1'b0;
    checks++; if (mask_q !== 4'b0000) begin errors++; $display("FAIL mask_clear got=%b exp=0000", mask_q); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mask_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'b0011;
    step();
    checks++; if (out_data !== 4'b0010) begin errors++; $display("FAIL bp_first got=%b exp=0010", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
    in_data = 4'b0101;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop got=%b exp=0", in_ready); end
    checks++; if (out_data !== 4'b0010) begin errors++; $display("FAIL bp_hold got=%b exp=0010", out_data); end
    in_data = 4'b1111;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got=%b exp=0", in_ready); end
    checks++; if (beat_cnt !== 4'd5) begin errors++; $display("FAIL bp_no_accept got=%0d exp=5", beat_cnt); end
    checks++; if (out_valid !== 1'b1 || out_data !== 4'b0010) begin errors++; $display("FAIL bp_hold2 got=%b/%b exp=1/0010", out_valid, out_data); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++; if (out_data !== 4'b0100) begin errors++; $display("FAIL bp_second got=%b exp=0100", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    logic [3:0] q[$];
    logic [3:0] exp_d;
    logic [3:0] cnt_model;
    int acc_n;
    int cyc;
    acc_n = 0; cyc = 0; cnt_model = 4'd5;
    while (acc_n < 1000 && cyc < 20000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_extra got=%b exp=none", out_data);
        end else begin
          exp_d = q.pop_front();
          if (out_data !== exp_d) begin errors++; $display("FAIL rand_data got=%b exp=%b", out_data, exp_d); end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data ^ 4'b0001);
        acc_n++;
        cnt_model = cnt_model + 4'd1;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_extra got=%b exp=none", out_data);
        end else begin
          exp_d = q.pop_front();
          if (out_data !== exp_d) begin errors++; $display("FAIL rand_data got=%b exp=%b", out_data, exp_d); end
        end
      end
      step();
    end
    checks++; if (acc_n != 1000) begin errors++; $display("FAIL rand_progress got=%0d exp=1000", acc_n); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_lost got=%0d exp=0", q.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_tail got=%b exp=0", out_valid); end
    checks++; if (beat_cnt !== cnt_model) begin errors++; $display("FAIL rand_cnt got=%0d exp=%0d", beat_cnt, cnt_model); end
  endtask

  task automatic test_wrap_and_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; in_data = 4'b0110;
    for (int i = 0; i < 17; i++) step();
    in_valid = 1'b0;
    checks++; if (beat_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt got=%0d exp=1", beat_cnt); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got=%b exp=1", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_valid got=%b exp=0", out_valid); end
    checks++; if (beat_cnt !== 4'd0) begin errors++; $display("FAIL async_cnt got=%0d exp=0", beat_cnt); end
    checks++; if (out_data !== 4'b0000) begin errors++; $display("FAIL async_data got=%b exp=0000", out_data); end
    @(posedge clk);
    #1 rst = 1'b0;
    in_data = 4'b1010; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 4'b1011) begin errors++; $display("FAIL resume got=%b/%b exp=1/1011", out_valid, out_data); end
    checks++; if (beat_cnt !== 4'd1) begin errors++; $display("FAIL resume_cnt got=%0d exp=1", beat_cnt); end
  endtask

`ifdef INV_STREAM_BANK_PARITY_EN
  task automatic test_parity();
    in_data = 4'b0110; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_data !== 4'b0111) begin errors++; $display("FAIL par_data got=%b exp=0111", out_data); end
    checks++; if (out_parity !== 1'b1) begin errors++; $display("FAIL par_bit got=%b exp=1", out_parity); end
  endtask
`endif

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_mask = '0;
    test_reset();
    test_basic();
    test_mask();
    test_backpressure();
    test_random();
    test_wrap_and_reset();
`ifdef INV_STREAM_BANK_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
